// File: rtl/board_renderer.sv
// board_renderer: walks board RAM and streams clear, cell and turn-indicator
// pixels to the VGA adapter, one registered pixel per cycle.
module board_renderer #(
    parameter int BOARD_W  = 8,
    parameter int BOARD_H  = 8,
    parameter int CELL_PX  = 16,
    parameter int PITCH    = 17,
    parameter int ORIGIN_X = 1,
    parameter int ORIGIN_Y = 1,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int IND_X    = 138,
    parameter int IND_Y    = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [2:0] tgt_x,
    input  logic [2:0] tgt_y,
    input  logic [2:0] cur_x,
    input  logic [2:0] cur_y,
    input  logic       sel_valid,
    input  logic [2:0] sel_x,
    input  logic [2:0] sel_y,
    input  logic       turn_player,
    output logic [5:0] cell_addr,
    input  logic [5:0] cell_value,
    output logic [4:0] glyph_code,
    output logic [7:0] glyph_idx,
    input  logic       glyph_bit,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    localparam int LW   = $clog2(CELL_PX);
    localparam int CW   = 2 * LW;
    localparam int NCLR = SCREEN_W * SCREEN_H;
    localparam int KW   = $clog2(NCLR);

    // state | meaning
    // IDLE  | waiting for start
    // CLEAR | full-screen white raster, x fastest
    // FETCH | board RAM address presented
    // WAIT  | RAM data returns, latched at end of cycle
    // DRAW  | one cell's pixels
    // IND   | turn-indicator square
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT,
        S_DRAW,
        S_IND,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [2:0]      cx_q, cx_d;
    logic [2:0]      cy_q, cy_d;
    logic [5:0]      cell_q, cell_d;
    logic [CW-1:0]   c_q, c_d;
    logic [KW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [7:0]      clr_x_q, clr_x_d;
    logic [6:0]      clr_y_q, clr_y_d;
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            plot_q, plot_d;

    logic [LW-1:0]   col;
    logic [LW-1:0]   row;
    logic            c_last;
    logic [8:0]      px9;
    logic [8:0]      py9;
    logic            unused_px;
    logic            on_edge;
    logic            sel_hit;
    logic            cur_hit;
    logic            owner;
    logic [4:0]      code;
    logic [2:0]      cell_colour;

    assign col        = c_q[LW-1:0];
    assign row        = c_q[CW-1:LW];
    assign c_last     = (c_q == CW'(CELL_PX * CELL_PX - 1));
    assign owner      = cell_q[5];
    assign code       = cell_q[4:0];

    assign cell_addr  = {cy_q, cx_q};
    assign glyph_code = cell_q[4:0];
    assign glyph_idx  = 8'(c_q);
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);

    // Pixel coordinates are formed at 9 bits and truncated onto the output bus.
    always_comb begin
        px9 = 9'(ORIGIN_X) + 9'(cx_q) * 9'(PITCH) + 9'(col);
        py9 = 9'(ORIGIN_Y) + 9'(cy_q) * 9'(PITCH) + 9'(row);
        if (state_q == S_IND) begin
            px9 = 9'(IND_X) + 9'(col);
            py9 = 9'(IND_Y) + 9'(row);
        end
    end

    assign unused_px = ^{px9[8], py9[8:7]};

    assign on_edge = (row == '0) || (row == LW'(CELL_PX - 1)) ||
                     (col == '0) || (col == LW'(CELL_PX - 1));
    assign sel_hit = sel_valid && (sel_x == cx_q) && (sel_y == cy_q);
    assign cur_hit = (cur_x == cx_q) && (cur_y == cy_q);

    // Glyphs are only revealed for the side whose turn it is.
    always_comb begin
        cell_colour = owner ? 3'b100 : 3'b001;
        if (sel_hit && on_edge) begin
            cell_colour = 3'b010;
        end else if (code == 5'b00000) begin
            cell_colour = 3'b000;
        end else if (code == 5'b11111) begin
            cell_colour = 3'b111;
        end else if (glyph_bit && (owner == turn_player)) begin
            cell_colour = 3'b111;
        end else if (cur_hit) begin
            cell_colour = owner ? 3'b110 : 3'b011;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        cell_d    = cell_q;
        c_d       = c_q;
        clr_cnt_d = clr_cnt_q;
        clr_x_d   = clr_x_q;
        clr_y_d   = clr_y_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    c_d    = '0;
                    cx_d   = '0;
                    cy_d   = '0;
                    case (mode)
                        2'b00: begin
                            state_d   = S_CLEAR;
                            clr_cnt_d = KW'(NCLR - 1);
                            clr_x_d   = '0;
                            clr_y_d   = '0;
                        end
                        2'b01: state_d = S_FETCH;
                        2'b10: begin
                            state_d = S_FETCH;
                            cx_d    = tgt_x;
                            cy_d    = tgt_y;
                        end
                        default: state_d = S_IND;
                    endcase
                end
            end

            S_CLEAR: begin
                plot_d   = 1'b1;
                x_d      = clr_x_q;
                y_d      = clr_y_q;
                colour_d = 3'b111;
                if (clr_x_q == 8'(SCREEN_W - 1)) begin
                    clr_x_d = '0;
                    clr_y_d = clr_y_q + 7'd1;
                end else begin
                    clr_x_d = clr_x_q + 8'd1;
                end
                if (clr_cnt_q == '0) begin
                    state_d = S_FETCH;
                    cx_d    = '0;
                    cy_d    = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q - KW'(1);
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
                c_d     = '0;
            end

            S_WAIT: begin
                state_d = S_DRAW;
                cell_d  = cell_value;
            end

            S_DRAW: begin
                plot_d   = 1'b1;
                x_d      = px9[7:0];
                y_d      = py9[6:0];
                colour_d = cell_colour;
                c_d      = c_q + CW'(1);
                if (c_last) begin
                    c_d = '0;
                    if (mode_q == 2'b10) begin
                        state_d = S_DONE;
                    end else if (cx_q == 3'(BOARD_W - 1)) begin
                        cx_d = '0;
                        if (cy_q == 3'(BOARD_H - 1)) begin
                            cy_d    = '0;
                            state_d = S_IND;
                        end else begin
                            cy_d    = cy_q + 3'd1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        cx_d    = cx_q + 3'd1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_IND: begin
                plot_d   = 1'b1;
                x_d      = px9[7:0];
                y_d      = py9[6:0];
                colour_d = turn_player ? 3'b100 : 3'b001;
                c_d      = c_q + CW'(1);
                if (c_last) begin
                    c_d     = '0;
                    state_d = S_DONE;
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            cell_q    <= '0;
            c_q       <= '0;
            clr_cnt_q <= '0;
            clr_x_q   <= '0;
            clr_y_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            cell_q    <= cell_d;
            c_q       <= c_d;
            clr_cnt_q <= clr_cnt_d;
            clr_x_q   <= clr_x_d;
            clr_y_q   <= clr_y_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
        end
    end

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: expected pixels are queued from a
// reference model at start and compared as the DUT plots them.
module tb_board_renderer;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [2:0] tgt_x, tgt_y;
    logic [2:0] cur_x, cur_y;
    logic       sel_valid;
    logic [2:0] sel_x, sel_y;
    logic       turn_player;
    logic [5:0] cell_addr;
    logic [5:0] cell_value;
    logic [4:0] glyph_code;
    logic [7:0] glyph_idx;
    logic       glyph_bit;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t       sb[$];
    pix_t       mon_e;
    logic [5:0] mem[64];
    logic       rom_hash;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         plot_cnt = 0;
    int         done_cnt = 0;

    board_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .tgt_x      (tgt_x),
        .tgt_y      (tgt_y),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .sel_valid  (sel_valid),
        .sel_x      (sel_x),
        .sel_y      (sel_y),
        .turn_player(turn_player),
        .cell_addr  (cell_addr),
        .cell_value (cell_value),
        .glyph_code (glyph_code),
        .glyph_idx  (glyph_idx),
        .glyph_bit  (glyph_bit),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic rom_bit(input logic [4:0] code, input logic [7:0] idx, input logic hash);
        int v;
        if (!hash) return idx == 8'd17;
        v = int'(idx) ^ (int'(code) * 7);
        return (v % 3) == 0;
    endfunction

    always_comb glyph_bit = rom_bit(glyph_code, glyph_idx, rom_hash);

    always @(posedge clk) cell_value <= mem[cell_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && plot) begin
            plot_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_plot", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pixel", 32'({x, y, colour}), 32'(mon_e));
            end
        end
        if (!reset && done) done_cnt++;
    end

    function automatic logic [2:0] exp_colour(input int cx, input int cy, input int r, input int c,
                                              input logic [5:0] v);
        logic [4:0] code;
        logic       own;
        code = v[4:0];
        own  = v[5];
        if (sel_valid && cx == int'(sel_x) && cy == int'(sel_y) &&
            (r == 0 || r == 15 || c == 0 || c == 15)) return 3'b010;
        if (code == 5'd0) return 3'b000;
        if (code == 5'd31) return 3'b111;
        if (rom_bit(code, 8'(r * 16 + c), rom_hash) && own == turn_player) return 3'b111;
        if (cx == int'(cur_x) && cy == int'(cur_y)) return own ? 3'b110 : 3'b011;
        return own ? 3'b100 : 3'b001;
    endfunction

    task automatic push_cell(input int cx, input int cy);
        pix_t p;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                p.px = 8'(1 + cx * 17 + c);
                p.py = 7'(1 + cy * 17 + r);
                p.pc = exp_colour(cx, cy, r, c, mem[cy * 8 + cx]);
                sb.push_back(p);
            end
        end
    endtask

    task automatic push_ind();
        pix_t p;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                p.px = 8'(138 + c);
                p.py = 7'(30 + r);
                p.pc = turn_player ? 3'b100 : 3'b001;
                sb.push_back(p);
            end
        end
    endtask

    task automatic push_clear();
        pix_t p;
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                p.px = 8'(xx);
                p.py = 7'(yy);
                p.pc = 3'b111;
                sb.push_back(p);
            end
        end
    endtask

    task automatic push_model(input logic [1:0] m, input int tx, input int ty);
        if (m == 2'b00) push_clear();
        if (m <= 2'b01) begin
            for (int cy = 0; cy < 8; cy++)
                for (int cx = 0; cx < 8; cx++)
                    push_cell(cx, cy);
            push_ind();
        end
        if (m == 2'b10) push_cell(tx, ty);
        if (m == 2'b11) push_ind();
    endtask

    task automatic render(input string tag, input logic [1:0] m, input logic [2:0] tx,
                          input logic [2:0] ty, input int exp_cycles, input int exp_plots);
        int cnt;
        push_model(m, int'(tx), int'(ty));
        plot_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        mode  = m;
        tgt_x = tx;
        tgt_y = ty;
        start = 1'b1;
        cnt   = 0;
        do begin
            @(negedge clk);
            cnt++;
            start = 1'b0;
            mode  = ~m;
            tgt_x = ~tx;
            tgt_y = ~ty;
            if (cnt == 1) check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        end while (!done && cnt < exp_cycles + 100);
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, 32'(cnt + 1), 32'(exp_cycles));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_plots"}, 32'(plot_cnt), 32'(exp_plots));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset = 1'b1;
        start = 1'b0;
        mode = 2'b00;
        tgt_x = 3'd0;
        tgt_y = 3'd0;
        cur_x = 3'd0;
        cur_y = 3'd0;
        sel_valid = 1'b0;
        sel_x = 3'd0;
        sel_y = 3'd0;
        turn_player = 1'b0;
        rom_hash = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 6'd0;

        repeat (3) @(negedge clk);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_cell_addr", 32'(cell_addr), 32'd0);
        check("rst_glyph_idx", 32'(glyph_idx), 32'd0);
        reset = 1'b0;

        // abort a clear part-way through
        push_clear();
        @(negedge clk);
        mode  = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("abort_plot_before", 32'(plot), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_plot", 32'(plot), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("abort_plot_next", 32'(plot), 32'd0);
        check("abort_busy_next", 32'(busy), 32'd0);
        reset = 1'b0;
        sb.delete();

        render("m01_empty", 2'b01, 3'd0, 3'd0, 1 + 64 * 258 + 256 + 1, 64 * 256 + 256);

        mem[{3'd5, 3'd3}] = 6'b100100;
        turn_player = 1'b1;
        render("m10_own", 2'b10, 3'd3, 3'd5, 260, 256);
        turn_player = 1'b0;
        render("m10_hidden", 2'b10, 3'd3, 3'd5, 260, 256);
        cur_x = 3'd3;
        cur_y = 3'd5;
        render("m10_cursor", 2'b10, 3'd3, 3'd5, 260, 256);
        cur_x = 3'd0;
        cur_y = 3'd0;
        turn_player = 1'b1;
        sel_valid = 1'b1;
        sel_x = 3'd3;
        sel_y = 3'd5;
        render("m10_select", 2'b10, 3'd3, 3'd5, 260, 256);
        sel_valid = 1'b0;
        turn_player = 1'b0;
        render("m11_ind", 2'b11, 3'd0, 3'd0, 258, 256);

        rom_hash = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 6'($urandom);
        mem[0] = 6'b000000;
        mem[1] = 6'b011111;
        mem[2] = 6'b111111;
        mem[9] = 6'b000101;
        cur_x = 3'd2;
        cur_y = 3'd1;
        sel_valid = 1'b1;
        sel_x = 3'd4;
        sel_y = 3'd4;
        turn_player = 1'b1;
        render("m00_full", 2'b00, 3'd0, 3'd0, 1 + 19200 + 64 * 258 + 256 + 1, 19200 + 64 * 256 + 256);

        // start held high: back-to-back renders, mode change after acceptance
        rom_hash = 1'b0;
        sel_valid = 1'b0;
        cur_x = 3'd0;
        cur_y = 3'd0;
        turn_player = 1'b1;
        mem[{3'd5, 3'd3}] = 6'b100100;
        push_model(2'b10, 3, 5);
        @(negedge clk);
        mode  = 2'b10;
        tgt_x = 3'd3;
        tgt_y = 3'd5;
        start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            mode  = 2'b11;
            tgt_x = 3'd0;
            tgt_y = 3'd0;
        end while (!done && k < 400);
        check("hold_first_cycles", 32'(k + 1), 32'd260);
        check("hold_busy_at_done", 32'(busy), 32'd0);
        push_model(2'b11, 0, 0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) check("hold_idle_gap", 32'(busy), 32'd0);
            if (k == 2) begin
                check("hold_second_busy", 32'(busy), 32'd1);
                start = 1'b0;
            end
        end while (!done && k < 400);
        check("hold_second_cycles", 32'(k), 32'd258);
        @(negedge clk);
        check("hold_sb_empty", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("hold_idle_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
- Parametrised, self-sequencing board renderer for the Stratego VGA path.
- On a start pulse it walks board memory, fetches each cell code, and streams one pixel per cycle (x, y, colour, plot) to the VGA adapter.
- Supports full-screen clear, full board redraw, single-cell redraw and turn-indicator-only redraw, with cursor and selection highlighting.
- Sits between the game-control FSM (start/done) and the board RAM, the glyph ROM and the VGA adapter.

Parameters:
- BOARD_W, 8, cells per row
- BOARD_H, 8, cells per column
- CELL_PX, 16, cell side in pixels; power of two
- PITCH, 17, cell-to-cell spacing in pixels; must be greater than CELL_PX
- ORIGIN_X, 1, pixel x of cell (0,0)
- ORIGIN_Y, 1, pixel y of cell (0,0)
- SCREEN_W, 160, clear-region width
- SCREEN_H, 120, clear-region height
- IND_X, 138, turn-indicator x origin
- IND_Y, 30, turn-indicator y origin

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin a render; sampled only in IDLE
- mode  in  2  00 clear+board+indicator, 01 board+indicator, 10 single cell, 11 indicator only
- tgt_x  in  3  target cell x for mode 10
- tgt_y  in  3  target cell y for mode 10
- cur_x  in  3  cursor cell x (SW switches)
- cur_y  in  3  cursor cell y
- sel_valid  in  1  a piece is selected
- sel_x  in  3  selected cell x
- sel_y  in  3  selected cell y
- turn_player  in  1  0 blue, 1 red
- cell_addr  out  6  board RAM address, {y,x}
- cell_value  in  6  RAM data; [5] owner, [4:0] code; 1-cycle read latency
- glyph_code  out  5  glyph ROM code (latched cell_value[4:0])
- glyph_idx  out  8  pixel index, row*CELL_PX+col
- glyph_bit  in  1  combinational ROM bit for glyph_code/glyph_idx
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  RGB
- plot  out  1  pixel write enable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: x, y, colour, plot, busy, done, cell_addr, glyph_idx and all counters go to 0; FSM goes to IDLE. Reset during a render aborts it immediately with no further plots.
- States: IDLE, CLEAR, FETCH, WAIT, DRAW, IND, DONE.
- IDLE, start=1: latch mode, tgt_x and tgt_y; set busy. Next state:
  - mode 00 -> CLEAR
  - mode 01 -> FETCH at cell (0,0)
  - mode 10 -> FETCH at cell (tgt_x,tgt_y)
  - mode 11 -> IND
- start while busy is ignored. mode and tgt_* changes after acceptance are ignored.
- CLEAR: SCREEN_W*SCREEN_H cycles, raster order with x fastest. Each cycle plots colour 111 (white background/grid). Then -> FETCH (0,0).
- FETCH: drive cell_addr; 1 cycle; plot=0.
- WAIT: 1 cycle; capture cell_value at the end of the cycle; plot=0.
- DRAW: CELL_PX^2 cycles with counter c (col = low bits, row = high bits).
  - x = ORIGIN_X + cx*PITCH + col
  - y = ORIGIN_Y + cy*PITCH + row
  - glyph_idx = c
  - colour, in priority order:
    1. sel_valid, the cell equals (sel_x,sel_y), and the pixel lies on the cell perimeter -> 010
    2. code 00000 -> 000
    3. code 11111 -> 111
    4. piece with glyph_bit=1 and owner==turn_player -> 111 (enemy glyphs stay hidden)
    5. piece at (cur_x,cur_y) -> owner ? 110 : 011
    6. any other piece -> owner ? 100 : 001
- After DRAW:
  - modes 00/01: advance cx, then cy (row-major); after the last cell -> IND, otherwise -> FETCH.
  - mode 10 -> DONE.
- IND: CELL_PX^2 cycles.
  - x = IND_X + col, y = IND_Y + row
  - colour = turn_player ? 100 : 001
  - then -> DONE.
- DONE: done=1 and busy=0 for one cycle; plot=0; -> IDLE.
- Pixel timing:
  - x, y, colour and plot are registered: they are valid in the cycle after the FSM computes them.
  - plot is high exactly once per pixel and low in every other state.
  - cur_*, sel_* and turn_player are sampled live each DRAW/IND cycle.
- Widths: x/y arithmetic is performed at 9 bits and truncated to 8/7. Parameters must keep all pixels on-screen; there is no clipping. The clear counter is sized by clog2(SCREEN_W*SCREEN_H).

Test Plan:
- Reset mid-CLEAR -> plot=0 and busy=0 the next cycle; a fresh start in mode 01 runs normally.
- Mode 01, all cells 000000, defaults -> exactly 64*256+256 = 16640 plots.
  - Cell (1,0) pixel (0,0) at x=18, y=1, colour 000.
  - Indicator pixels at x 138..153, y 30..45.
  - done pulses once; total start-to-done = 1 + 64*258 + 256 + 1 cycles.
- Mode 10, tgt=(3,5), cell_value=6'b100100, turn_player=1, glyph_bit=1 at idx 17, cursor elsewhere, no selection:
  - x=1+51+1=53, y=1+85+1=87 -> colour 111
  - all other pixels -> 100
  - 256 plots, then done.
- Same cell with turn_player=0 -> all 256 pixels 100 (glyph hidden). With cur=(3,5) -> all 110.
- sel_valid=1, sel=(3,5) -> the 60 perimeter pixels are 010; interior is unchanged.
- start held high throughout a render -> a second render begins only on the cycle after done; the first render's mode is unaffected by mode changes.
